ifetch_sram_bridge: RTL and testbench

Instruction-fetch slave that turns fetch requests from the core front end into reads on a single-port instruction SRAM and returns fetched words in order. It adds a parametrised response FIFO so `rsp_rdy` backpressure never drops SRAM read data. It supports up to DEPTH outstanding fetches, range and alignment checking with an error flag, and a single-cycle flush for branch redirects. It sits between the fetch stage (ifetch_if.slave side) and the instruction SRAM (sram_if.master side).

---
 rtl/ifetch_pkg.sv | 11 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/ifetch_sram_bridge.sv | 117 +++++++++++
 tb/tb_ifetch_sram_bridge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch SRAM bridge.
// The FIFO entry carries the fetched word plus its range/alignment error flag.
package ifetch_pkg;
    localparam int IFETCH_IR_W = 32;
    localparam logic [IFETCH_IR_W-1:0] IFETCH_NOP = 32'h0000_0013;

    typedef struct packed {
        logic                   err;
        logic [IFETCH_IR_W-1:0] ir;
    } fifo_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, a clear input and an occupancy count.
// A pop frees the head slot before a same-cycle push, so push+pop on a full FIFO is legal.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_s || do_pop_s);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    // Next-pointer computation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; clear behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push_s && !rst_i && !clr_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end
endmodule

// File: rtl/ifetch_sram_bridge.sv
// Fetch-request to single-port SRAM bridge: range/alignment check, one in-flight
// read slot and a credit-managed response FIFO so backpressure never drops data.
module ifetch_sram_bridge
    import ifetch_pkg::*;
#(
    parameter int              PC_W    = 32,
    parameter int              IR_W    = 32,
    parameter int              SRAM_AW = 10,
    parameter int              DEPTH   = 4,
    parameter logic [PC_W-1:0] PC_BASE = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               req_vld,
    output logic               req_rdy,
    input  logic [PC_W-1:0]    req_pc,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [IR_W-1:0]    rsp_ir,
    output logic               rsp_err,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_wen,
    output logic [IR_W-1:0]    sram_wdata,
    input  logic [IR_W-1:0]    sram_rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0]    offset_s;
    logic               legal_s;
    logic               accept_s;
    logic [AW:0]        fifo_cnt_s;
    logic [AW+1:0]      occ_s;
    logic               fifo_empty_s;
    logic               inflight_vld_q;
    logic               inflight_vld_d;
    logic               inflight_err_q;
    logic               inflight_err_d;
    logic [SRAM_AW-1:0] addr_q;
    logic [SRAM_AW-1:0] addr_d;
    fifo_entry_t        wr_entry_s;
    fifo_entry_t        head_s;

    // Offset-based range test avoids overflow of PC_BASE + window size.
    assign offset_s = req_pc - PC_BASE;
    assign legal_s  = (req_pc[1:0] == 2'b00) && (req_pc >= PC_BASE)
                   && ((offset_s >> (SRAM_AW + 2)) == {PC_W{1'b0}});

    assign occ_s    = {1'b0, fifo_cnt_s} + {{(AW+1){1'b0}}, inflight_vld_q};
    assign req_rdy  = !rst && !flush && (occ_s < (AW+2)'(DEPTH));
    assign accept_s = req_vld && req_rdy;

    assign sram_addr  = addr_d;
    assign sram_wen   = 1'b0;
    assign sram_wdata = {IR_W{1'b0}};

    // SRAM address and in-flight slot next state.
    always_comb begin
        addr_d         = addr_q;
        inflight_vld_d = accept_s;
        inflight_err_d = 1'b0;
        if (accept_s && legal_s) begin
            addr_d = SRAM_AW'(offset_s >> 2);
        end else begin
            addr_d = addr_q;
        end
        if (accept_s) begin
            inflight_err_d = !legal_s;
        end else begin
            inflight_err_d = 1'b0;
        end
    end

    // In-flight and address registers; flush has the same effect as reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inflight_vld_q <= 1'b0;
            inflight_err_q <= 1'b0;
            addr_q         <= {SRAM_AW{1'b0}};
        end else begin
            inflight_vld_q <= inflight_vld_d;
            inflight_err_q <= inflight_err_d;
            addr_q         <= addr_d;
        end
    end

    // FIFO write entry: illegal fetches substitute a NOP.
    always_comb begin
        wr_entry_s = '0;
        if (inflight_err_q) begin
            wr_entry_s.err = 1'b1;
            wr_entry_s.ir  = IFETCH_NOP;
        end else begin
            wr_entry_s.err = 1'b0;
            wr_entry_s.ir  = sram_rdata;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (flush),
        .push_i  (inflight_vld_q),
        .wdata_i (wr_entry_s),
        .pop_i   (rsp_vld && rsp_rdy),
        .rdata_o (head_s),
        .count_o (fifo_cnt_s),
        .empty_o (fifo_empty_s)
    );

    assign rsp_vld = !fifo_empty_s;
    assign rsp_ir  = rsp_vld ? head_s.ir : {IR_W{1'b0}};
    assign rsp_err = rsp_vld ? head_s.err : 1'b0;
endmodule

// File: tb/tb_ifetch_sram_bridge.sv
// Randomized scoreboard bench for ifetch_sram_bridge with an SRAM model.
// Expected responses are derived from the request PC and the SRAM image only.
module tb_ifetch_sram_bridge;
    localparam int          DEPTH   = 4;
    localparam int          SRAM_AW = 10;
    localparam logic [31:0] BASE    = 32'h0;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [31:0] req_pc = 32'h0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [31:0] rsp_ir;
    logic        rsp_err;
    logic [9:0]  sram_addr;
    logic        sram_wen;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    logic [31:0] mem [1024];

    typedef struct {
        logic [31:0] ir;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q[$];

    int tests = 0, fails = 0, cyc = 0, acc_cnt = 0, pop_cnt = 0, err_cnt = 0;
    logic        prev_rst = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_ir = 32'h0;
    logic        prev_err = 1'b0;

    ifetch_sram_bridge #(
        .PC_W(32), .IR_W(32), .SRAM_AW(SRAM_AW), .DEPTH(DEPTH), .PC_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_pc(req_pc),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_ir(rsp_ir), .rsp_err(rsp_err),
        .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) sram_rdata <= mem[sram_addr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_rsp(input logic [31:0] pc, input int c);
        exp_t   e;
        longint off;
        off   = longint'(pc) - longint'(BASE);
        e.cyc = c;
        if (pc[1:0] != 2'b00 || off < 0 || off >= 4 * 1024) begin
            e.ir  = NOP;
            e.err = 1'b1;
        end else begin
            e.ir  = mem[off / 4];
            e.err = 1'b0;
        end
        return e;
    endfunction

    // Monitor / scoreboard, sampling mid-cycle.
    always @(negedge clk) begin
        logic exp_vld;
        exp_t e;
        chk("req_rdy", req_rdy, (!rst && !flush && q.size() < DEPTH));
        exp_vld = (q.size() != 0) && (q[0].cyc + 2 <= cyc);
        chk("rsp_vld", rsp_vld, exp_vld);
        if (prev_rst) begin
            chk("rst rsp_ir", rsp_ir, 32'h0);
            chk("rst rsp_err", rsp_err, 1'b0);
            if (!req_vld) chk("rst sram_addr", sram_addr, 10'h0);
        end
        if (prev_stall) begin
            chk("stall rsp_ir", rsp_ir, prev_ir);
            chk("stall rsp_err", rsp_err, prev_err);
        end
        if (rsp_vld && rsp_rdy && exp_vld) begin
            e = q.pop_front();
            chk("rsp_ir", rsp_ir, e.ir);
            chk("rsp_err", rsp_err, e.err);
            pop_cnt++;
            if (rsp_err) err_cnt++;
        end
        if (req_vld && req_rdy) begin
            q.push_back(ref_rsp(req_pc, cyc));
            acc_cnt++;
        end
        if (rst || flush) q.delete();
        chk("occupancy", (q.size() <= DEPTH), 1'b1);
        prev_rst   = rst;
        prev_stall = rsp_vld && !rsp_rdy && !rst && !flush;
        prev_ir    = rsp_ir;
        prev_err   = rsp_err;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, p0, e0, n, guard;
        logic [31:0] pcs [7];
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | (i * 32'h0001_0001);
        repeat (3) step();
        rst = 1'b0;
        step();

        // back-to-back in-order fetches
        a0 = acc_cnt; p0 = pop_cnt;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_vld = 1'b1; req_pc = 32'(i * 4);
            step();
        end
        req_vld = 1'b0;
        repeat (4) step();
        chk("t1 accepts", acc_cnt - a0, 4);
        chk("t1 responses", pop_cnt - p0, 4);

        // credit limit under full backpressure
        a0 = acc_cnt; p0 = pop_cnt;
        rsp_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_vld = 1'b1; req_pc = 32'($urandom_range(0, 1023)) << 2;
            step();
        end
        chk("t2 accepts", acc_cnt - a0, DEPTH);
        chk("t2 req_rdy low", req_rdy, 1'b0);
        req_vld = 1'b0; rsp_rdy = 1'b1;
        repeat (8) step();
        chk("t2 drained", pop_cnt - p0, DEPTH);
        chk("t2 queue empty", q.size(), 0);

        // illegal PCs interleaved with legal ones
        pcs = '{32'h10, 32'h2, 32'h10, BASE + 32'h1000, 32'h14, 32'h3, 32'hFFC};
        e0 = err_cnt; p0 = pop_cnt;
        foreach (pcs[i]) begin
            req_vld = 1'b1; req_pc = pcs[i];
            step();
        end
        req_vld = 1'b0;
        repeat (5) step();
        chk("t3 responses", pop_cnt - p0, 7);
        chk("t3 errors", err_cnt - e0, 3);

        // flush with 3 buffered and 1 in flight
        a0 = acc_cnt; guard = 0;
        rsp_rdy = 1'b0;
        while (acc_cnt - a0 < 4 && guard < 20) begin
            req_vld = 1'b1; req_pc = 32'(guard * 4 + 32'h100);
            step(); guard++;
        end
        chk("t4 fill", acc_cnt - a0, 4);
        req_vld = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; rsp_rdy = 1'b1; p0 = pop_cnt;
        req_vld = 1'b1; req_pc = 32'h40;
        step();
        req_vld = 1'b0;
        repeat (5) step();
        chk("t4 post-flush responses", pop_cnt - p0, 1);

        // random backpressure, 1000 legal fetches
        a0 = acc_cnt; guard = 0;
        while (acc_cnt - a0 < 1000 && guard < 20000) begin
            req_vld = ($urandom_range(0, 3) != 0);
            req_pc  = 32'($urandom_range(0, 1023)) << 2;
            rsp_rdy = $urandom_range(0, 1) == 1;
            step(); guard++;
        end
        chk("t5 budget", (guard < 20000), 1'b1);
        req_vld = 1'b0; rsp_rdy = 1'b1;
        repeat (8) step();
        chk("t5 queue empty", q.size(), 0);

        // reset mid-burst then a fresh fetch
        for (int i = 0; i < 3; i++) begin
            req_vld = 1'b1; req_pc = 32'(i * 4 + 32'h200);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; req_vld = 1'b0;
        step();
        p0 = pop_cnt;
        req_vld = 1'b1; req_pc = 32'h0;
        step();
        req_vld = 1'b0;
        repeat (4) step();
        chk("t6 fresh fetch", pop_cnt - p0, 1);
        chk("sram_wen", sram_wen, 1'b0);
        chk("sram_wdata", sram_wdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
